alu_rs: RTL and testbench

Reservation station for the scalar ALU. Holds renamed integer and branch-compare micro-ops from the decoder until both operands are known, snoops the result buses for missing operands, and dispatches at most one ready entry per cycle to `scalar_alu`. It sits between decode/rename (upstream) and `scalar_alu` (downstream).

---
 rtl/alu_rs_pkg.sv | 72 +++++++
 rtl/rs_first_set.sv | 22 ++
 rtl/alu_rs.sv | 139 +++++++++++++
 tb/tb_alu_rs.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// rtl/alu_rs_pkg.sv - shared widths, entry types and operand snoop helper for alu_rs
package alu_rs_pkg;

  localparam int RS_TYPE_BIT         = 4;
  localparam int ROB_WIDTH_BIT       = 4;
  localparam int DEFAULT_RS_SIZE_BIT = 3;

  typedef logic [RS_TYPE_BIT-1:0]   rs_type_t;
  typedef logic [ROB_WIDTH_BIT-1:0] rob_id_t;

  // Work-type encoding shared with scalar_alu
  typedef enum logic [RS_TYPE_BIT-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_BEQ = 4'd5
  } alu_op_e;

  typedef struct packed {
    logic        has_dep;
    rob_id_t     dep;
    logic [31:0] value;
  } operand_t;

  typedef struct packed {
    logic     busy;
    rs_type_t op_type;
    rob_id_t  rob_id;
    operand_t src1;
    operand_t src2;
  } rs_entry_t;

  function automatic operand_t make_operand(
    input logic        has_dep,
    input rob_id_t     dep,
    input logic [31:0] value
  );
    operand_t op;
    op.has_dep = has_dep;
    op.dep     = dep;
    op.value   = value;
    return op;
  endfunction

  // Resolve a pending operand against both result buses; the ALU bus wins
  // when both match since they carry the same value anyway.
  function automatic operand_t snoop(
    input operand_t    op,
    input logic        alu_ready,
    input rob_id_t     alu_rob_id,
    input logic [31:0] alu_value,
    input logic        lsb_ready,
    input rob_id_t     lsb_rob_id,
    input logic [31:0] lsb_value
  );
    operand_t r;
    r = op;
    if (op.has_dep) begin
      if (alu_ready && (alu_rob_id == op.dep)) begin
        r.has_dep = 1'b0;
        r.value   = alu_value;
      end else if (lsb_ready && (lsb_rob_id == op.dep)) begin
        r.has_dep = 1'b0;
        r.value   = lsb_value;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_first_set.sv
// rtl/rs_first_set.sv - find lowest set bit of an N-bit vector with found flag
module rs_first_set #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    idx   = '0;
    found = |vec;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - scalar ALU reservation station with result-bus wake-up
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE_BIT = DEFAULT_RS_SIZE_BIT
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear_in,
  input  logic                     inst_valid,
  input  logic [RS_TYPE_BIT-1:0]   inst_type,
  input  logic [31:0]              inst_r1,
  input  logic [31:0]              inst_r2,
  input  logic                     inst_has_dep1,
  input  logic                     inst_has_dep2,
  input  logic [ROB_WIDTH_BIT-1:0] inst_dep1,
  input  logic [ROB_WIDTH_BIT-1:0] inst_dep2,
  input  logic [ROB_WIDTH_BIT-1:0] inst_rob_id,
  output logic                     full,
  input  logic                     alu_ready,
  input  logic [ROB_WIDTH_BIT-1:0] alu_rob_id,
  input  logic [31:0]              alu_value,
  input  logic                     lsb_ready,
  input  logic [ROB_WIDTH_BIT-1:0] lsb_rob_id,
  input  logic [31:0]              lsb_value,
  output logic                     exec_valid,
  output logic [RS_TYPE_BIT-1:0]   exec_type,
  output logic [31:0]              exec_r1,
  output logic [31:0]              exec_r2,
  output logic [ROB_WIDTH_BIT-1:0] exec_rob_id
);

  localparam int ENTRIES = 1 << RS_SIZE_BIT;

  rs_entry_t               entries [ENTRIES];
  logic [ENTRIES-1:0]      busy_vec;
  logic [ENTRIES-1:0]      free_vec;
  logic [ENTRIES-1:0]      ready_vec;
  logic [RS_SIZE_BIT-1:0]  alloc_idx;
  logic                    alloc_found;
  logic [RS_SIZE_BIT-1:0]  disp_idx;
  logic                    disp_found;
  operand_t                new_src1;
  operand_t                new_src2;

  // Per-slot status vectors from the registered entry state
  always_comb begin
    busy_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      busy_vec[i]  = entries[i].busy;
      ready_vec[i] = entries[i].busy && !entries[i].src1.has_dep
                     && !entries[i].src2.has_dep;
    end
    free_vec = ~busy_vec;
  end

  assign full = &busy_vec;

  rs_first_set #(
    .N     (ENTRIES),
    .IDX_W (RS_SIZE_BIT)
  ) u_free_sel (
    .vec   (free_vec),
    .idx   (alloc_idx),
    .found (alloc_found)
  );

  rs_first_set #(
    .N     (ENTRIES),
    .IDX_W (RS_SIZE_BIT)
  ) u_ready_sel (
    .vec   (ready_vec),
    .idx   (disp_idx),
    .found (disp_found)
  );

  // Incoming operands pick up a broadcast landing in the same cycle
  always_comb begin
    new_src1 = snoop(make_operand(inst_has_dep1, inst_dep1, inst_r1),
                     alu_ready, alu_rob_id, alu_value,
                     lsb_ready, lsb_rob_id, lsb_value);
    new_src2 = snoop(make_operand(inst_has_dep2, inst_dep2, inst_r2),
                     alu_ready, alu_rob_id, alu_value,
                     lsb_ready, lsb_rob_id, lsb_value);
  end

  // Entry storage, wake-up, dispatch and allocate; everything frozen while rdy_in is low
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries[i] <= '0;
      end
      exec_valid  <= 1'b0;
      exec_type   <= '0;
      exec_r1     <= '0;
      exec_r2     <= '0;
      exec_rob_id <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        for (int i = 0; i < ENTRIES; i++) begin
          entries[i].busy <= 1'b0;
        end
        exec_valid <= 1'b0;
      end else begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (entries[i].busy) begin
            entries[i].src1 <= snoop(entries[i].src1, alu_ready, alu_rob_id, alu_value,
                                     lsb_ready, lsb_rob_id, lsb_value);
            entries[i].src2 <= snoop(entries[i].src2, alu_ready, alu_rob_id, alu_value,
                                     lsb_ready, lsb_rob_id, lsb_value);
          end
        end

        if (disp_found) begin
          exec_valid             <= 1'b1;
          exec_type              <= entries[disp_idx].op_type;
          exec_r1                <= entries[disp_idx].src1.value;
          exec_r2                <= entries[disp_idx].src2.value;
          exec_rob_id            <= entries[disp_idx].rob_id;
          entries[disp_idx].busy <= 1'b0;
        end else begin
          exec_valid <= 1'b0;
        end

        // A micro-op offered while full is dropped; the free slot is never the dispatch slot
        if (inst_valid && alloc_found) begin
          entries[alloc_idx].busy    <= 1'b1;
          entries[alloc_idx].op_type <= inst_type;
          entries[alloc_idx].rob_id  <= inst_rob_id;
          entries[alloc_idx].src1    <= new_src1;
          entries[alloc_idx].src2    <= new_src2;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - scoreboard bench for alu_rs
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        clear_in = 1'b0;
  logic        inst_valid = 1'b0;
  rs_type_t    inst_type = '0;
  logic [31:0] inst_r1 = '0;
  logic [31:0] inst_r2 = '0;
  logic        inst_has_dep1 = 1'b0;
  logic        inst_has_dep2 = 1'b0;
  rob_id_t     inst_dep1 = '0;
  rob_id_t     inst_dep2 = '0;
  rob_id_t     inst_rob_id = '0;
  logic        full;
  logic        alu_ready = 1'b0;
  rob_id_t     alu_rob_id = '0;
  logic [31:0] alu_value = '0;
  logic        lsb_ready = 1'b0;
  rob_id_t     lsb_rob_id = '0;
  logic [31:0] lsb_value = '0;
  logic        exec_valid;
  rs_type_t    exec_type;
  logic [31:0] exec_r1;
  logic [31:0] exec_r2;
  rob_id_t     exec_rob_id;

  typedef struct {
    rs_type_t    t;
    logic [31:0] r1;
    logic [31:0] r2;
    rob_id_t     rob;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic rdy_q = 1'b0;

  alu_rs #(.RS_SIZE_BIT(3)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .clear_in      (clear_in),
    .inst_valid    (inst_valid),
    .inst_type     (inst_type),
    .inst_r1       (inst_r1),
    .inst_r2       (inst_r2),
    .inst_has_dep1 (inst_has_dep1),
    .inst_has_dep2 (inst_has_dep2),
    .inst_dep1     (inst_dep1),
    .inst_dep2     (inst_dep2),
    .inst_rob_id   (inst_rob_id),
    .full          (full),
    .alu_ready     (alu_ready),
    .alu_rob_id    (alu_rob_id),
    .alu_value     (alu_value),
    .lsb_ready     (lsb_ready),
    .lsb_rob_id    (lsb_rob_id),
    .lsb_value     (lsb_value),
    .exec_valid    (exec_valid),
    .exec_type     (exec_type),
    .exec_r1       (exec_r1),
    .exec_r2       (exec_r2),
    .exec_rob_id   (exec_rob_id)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) rdy_q <= rdy_in;

  // Monitor: every dispatch registered at an active edge must match the oldest expectation
  always @(negedge clk_in) begin
    if (rst_in && rdy_q && exec_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_dispatch: got type=%0d r1=%h r2=%h rob=%0d, none expected",
                 exec_type, exec_r1, exec_r2, exec_rob_id);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (exec_type !== e.t || exec_r1 !== e.r1 || exec_r2 !== e.r2 || exec_rob_id !== e.rob) begin
          n_err++;
          $display("FAIL dispatch_payload: got type=%0d r1=%h r2=%h rob=%0d, want type=%0d r1=%h r2=%h rob=%0d",
                   exec_type, exec_r1, exec_r2, exec_rob_id, e.t, e.r1, e.r2, e.rob);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic push(input rs_type_t t, input logic [31:0] r1, input logic [31:0] r2, input rob_id_t rob);
    exp_t e;
    e.t = t; e.r1 = r1; e.r2 = r2; e.rob = rob;
    sb.push_back(e);
  endtask

  task automatic set_inst(input rs_type_t t, input logic [31:0] r1, input logic [31:0] r2,
                          input logic h1, input rob_id_t d1, input logic h2, input rob_id_t d2,
                          input rob_id_t rob);
    inst_valid = 1'b1; inst_type = t; inst_r1 = r1; inst_r2 = r2;
    inst_has_dep1 = h1; inst_dep1 = d1; inst_has_dep2 = h2; inst_dep2 = d2;
    inst_rob_id = rob;
  endtask

  task automatic issue(input rs_type_t t, input logic [31:0] r1, input logic [31:0] r2,
                       input logic h1, input rob_id_t d1, input logic h2, input rob_id_t d2,
                       input rob_id_t rob);
    set_inst(t, r1, r2, h1, d1, h2, d2, rob);
    step();
    inst_valid = 1'b0;
  endtask

  // Blocked entry i waits on ROB 8+i, carries rob id i and r2 = i*16
  task automatic fill_blocked(input int n);
    for (int i = 0; i < n; i++) begin
      issue(4'd3, 32'h0, 32'(i * 16), 1'b1, rob_id_t'(8 + i), 1'b0, 4'd0, rob_id_t'(i));
    end
  endtask

  task automatic bus_alu(input rob_id_t rob, input logic [31:0] val);
    alu_ready = 1'b1; alu_rob_id = rob; alu_value = val;
  endtask

  task automatic bus_lsb(input rob_id_t rob, input logic [31:0] val);
    lsb_ready = 1'b1; lsb_rob_id = rob; lsb_value = val;
  endtask

  task automatic bus_idle();
    alu_ready = 1'b0; lsb_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    step(2);
    chk("rst_exec_valid", 32'(exec_valid), 32'h0);
    chk("rst_exec_type", 32'(exec_type), 32'h0);
    chk("rst_exec_r1", exec_r1, 32'h0);
    chk("rst_exec_r2", exec_r2, 32'h0);
    chk("rst_exec_rob", 32'(exec_rob_id), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    rst_in = 1'b1;
    step(2);

    // Operand-ready add
    push(4'd0, 32'd5, 32'd7, 4'd3);
    issue(4'd0, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    chk("t1_not_yet", 32'(exec_valid), 32'h0);
    chk("t1_full", 32'(full), 32'h0);
    step();
    chk("t1_latency", 32'(exec_valid), 32'h1);
    step(2);
    chk("t1_drained", 32'(sb.size()), 32'h0);

    // Wait on the ALU bus
    issue(4'd1, 32'h0, 32'd3, 1'b1, 4'd2, 1'b0, 4'd0, 4'd5);
    step(3);
    push(4'd1, 32'h10, 32'd3, 4'd5);
    bus_alu(4'd2, 32'h10);
    step();
    bus_idle();
    step();
    chk("t2_wake_dispatch", 32'(exec_valid), 32'h1);
    step(2);
    chk("t2_drained", 32'(sb.size()), 32'h0);

    // Same-cycle forwarding from the LSB bus
    push(4'd2, 32'd9, 32'hABCD, 4'd6);
    set_inst(4'd2, 32'd9, 32'h0, 1'b0, 4'd0, 1'b1, 4'd4, 4'd6);
    bus_lsb(4'd4, 32'hABCD);
    step();
    inst_valid = 1'b0;
    bus_idle();
    step(3);
    chk("t3_drained", 32'(sb.size()), 32'h0);

    // Fill, then wake entries 5 and 2 together
    fill_blocked(8);
    chk("t4_full_set", 32'(full), 32'h1);
    push(4'd3, 32'h22, 32'h20, 4'd2);
    push(4'd3, 32'h55, 32'h50, 4'd5);
    bus_alu(4'd13, 32'h55);
    bus_lsb(4'd10, 32'h22);
    step();
    bus_idle();
    chk("t4_full_hold", 32'(full), 32'h1);
    step();
    chk("t4_full_fall", 32'(full), 32'h0);
    step(2);
    chk("t4_drained", 32'(sb.size()), 32'h0);

    // Drain entries 0, 1 and 3, leaving 4, 6 and 7 busy
    push(4'd3, 32'hA0, 32'h00, 4'd0);
    push(4'd3, 32'hA1, 32'h10, 4'd1);
    push(4'd3, 32'hA3, 32'h30, 4'd3);
    bus_alu(4'd8, 32'hA0);
    bus_lsb(4'd9, 32'hA1);
    step();
    bus_idle();
    bus_alu(4'd11, 32'hA3);
    step();
    bus_idle();
    step(4);
    chk("t5_pre_drained", 32'(sb.size()), 32'h0);

    // Flush with a concurrent ready micro-op
    clear_in = 1'b1;
    set_inst(4'd0, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1);
    step();
    clear_in = 1'b0;
    inst_valid = 1'b0;
    chk("t5_full_after_clear", 32'(full), 32'h0);
    step(3);
    fill_blocked(7);
    chk("t5_seven_not_full", 32'(full), 32'h0);
    fill_blocked(1);
    chk("t5_eight_full", 32'(full), 32'h1);

    // 7/8 busy: allocate and dispatch in the same cycle keeps 7
    clear_in = 1'b1;
    step();
    clear_in = 1'b0;
    fill_blocked(7);
    push(4'd3, 32'h33, 32'h30, 4'd3);
    bus_alu(4'd11, 32'h33);
    step();
    bus_idle();
    issue(4'd3, 32'h0, 32'h70, 1'b1, 4'd15, 1'b0, 4'd0, 4'd7);
    chk("t5_alloc_disp_7", 32'(full), 32'h0);
    issue(4'd3, 32'h0, 32'h80, 1'b1, 4'd14, 1'b0, 4'd0, 4'd8);
    chk("t5_refill_full", 32'(full), 32'h1);
    clear_in = 1'b1;
    step();
    clear_in = 1'b0;
    step();
    chk("t5_drained", 32'(sb.size()), 32'h0);

    // Pause with a ready entry and an ignored broadcast
    issue(4'd5, 32'h0, 32'h8, 1'b1, 4'd12, 1'b0, 4'd0, 4'd10);
    set_inst(4'd4, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
    step();
    inst_valid = 1'b0;
    rdy_in = 1'b0;
    step();
    chk("t6_pause_1", 32'(exec_valid), 32'h0);
    bus_alu(4'd12, 32'h99);
    step();
    bus_idle();
    chk("t6_pause_2", 32'(exec_valid), 32'h0);
    step();
    chk("t6_pause_3", 32'(exec_valid), 32'h0);
    push(4'd4, 32'd1, 32'd2, 4'd9);
    rdy_in = 1'b1;
    step(4);
    chk("t6_resume_drained", 32'(sb.size()), 32'h0);

    // Wake the blocked entry, then reset mid-dispatch
    push(4'd5, 32'h77, 32'h8, 4'd10);
    bus_alu(4'd12, 32'h77);
    step();
    bus_idle();
    step();
    chk("t6_dispatch_live", 32'(exec_valid), 32'h1);
    @(negedge clk_in);
    #2;
    rst_in = 1'b0;
    #1;
    chk("t6_async_exec_valid", 32'(exec_valid), 32'h0);
    chk("t6_async_exec_type", 32'(exec_type), 32'h0);
    chk("t6_async_exec_r1", exec_r1, 32'h0);
    chk("t6_async_exec_r2", exec_r2, 32'h0);
    chk("t6_async_exec_rob", 32'(exec_rob_id), 32'h0);
    chk("t6_async_full", 32'(full), 32'h0);
    step(2);
    rst_in = 1'b1;
    step(2);
    chk("final_drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
